// File: rtl/pm_animator.sv
// pm_animator: moves an 8x8 sprite one pixel per movement attempt on a
// 28x31 tile maze. Each attempt asks an external wall map about the
// leading-edge tile and then moves, wraps through the side tunnel, or stays.
module pm_animator #(
  parameter int X_INIT          = 108,
  parameter int Y_INIT          = 184,
  parameter int FRAMES_PER_STEP = 2
) (
  input  logic        S_AXI_ACLK,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic [31:0] pm_dir,
  input  logic [31:0] pm_mv,
  output logic        wq_valid,
  output logic [4:0]  wq_tx,
  output logic [4:0]  wq_ty,
  input  logic        wq_ready,
  input  logic        wq_wall,
  output logic [31:0] pm_x,
  output logic [31:0] pm_y,
  output logic [1:0]  pm_facing,
  output logic [1:0]  anim_frame
);

  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_UP    = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  // Rightmost pixel column; the tunnel joins it to column 0.
  localparam logic [7:0] X_WRAP    = 8'd216;
  localparam logic [4:0] ROW_LAST  = 5'd30;
  localparam logic [7:0] STEP_LAST = 8'(FRAMES_PER_STEP - 1);
  localparam logic [7:0] X_RST     = 8'(X_INIT);
  localparam logic [7:0] Y_RST     = 8'(Y_INIT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_QUERY = 2'd1,
    ST_MOVE  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_frame_cnt;
  logic [7:0]  r_x;
  logic [7:0]  r_y;
  logic [1:0]  r_facing;
  logic [1:0]  r_anim;
  logic [1:0]  r_dir;
  logic        r_wall;
  logic        r_wq_valid;
  logic [4:0]  r_wq_tx;
  logic [4:0]  r_wq_ty;

  logic        w_step;
  logic        w_start;
  logic [1:0]  w_dir;
  logic [4:0]  w_tx;
  logic [4:0]  w_ty;
  logic        w_skip;
  logic        w_oob;
  logic [7:0]  w_x_p8;
  logic [7:0]  w_x_m1;
  logic [7:0]  w_y_p8;
  logic [7:0]  w_y_m1;
  logic        w_unused;

  // Only the low bits of the command words carry meaning.
  assign w_unused = ^{pm_dir[31:2], pm_mv[31:1]};

  // Position never exceeds 216/240, so +8 stays inside 8 bits; -1 at zero
  // is never used because those cases are tunnel or out-of-range.
  assign w_x_p8 = r_x + 8'd8;
  assign w_x_m1 = r_x - 8'd1;
  assign w_y_p8 = r_y + 8'd8;
  assign w_y_m1 = r_y - 8'd1;

  assign w_step  = frame_tick && (r_frame_cnt == STEP_LAST);
  assign w_start = (r_state == ST_IDLE) && w_step && pm_mv[0];

  assign wq_valid   = r_wq_valid;
  assign wq_tx      = r_wq_tx;
  assign wq_ty      = r_wq_ty;
  assign pm_x       = {24'd0, r_x};
  assign pm_y       = {24'd0, r_y};
  assign pm_facing  = r_facing;
  assign anim_frame = r_anim;

  // Turns are only honoured when aligned to the grid; otherwise keep going.
  always_comb begin
    w_dir = pm_dir[1:0];
    if (pm_dir[1] && (r_x[2:0] != 3'd0)) begin
      w_dir = r_facing;
    end else if (!pm_dir[1] && (r_y[2:0] != 3'd0)) begin
      w_dir = r_facing;
    end else begin
      w_dir = pm_dir[1:0];
    end
  end

  // Leading-edge tile plus tunnel (skip) and off-maze (oob) classification.
  always_comb begin
    w_tx   = r_x[7:3];
    w_ty   = r_y[7:3];
    w_skip = 1'b0;
    w_oob  = 1'b0;
    case (w_dir)
      DIR_RIGHT: begin
        w_tx   = w_x_p8[7:3];
        w_skip = (r_x == X_WRAP);
      end
      DIR_LEFT: begin
        w_tx   = w_x_m1[7:3];
        w_skip = (r_x == 8'd0);
      end
      DIR_UP: begin
        w_ty  = w_y_m1[7:3];
        w_oob = (r_y == 8'd0);
      end
      DIR_DOWN: begin
        w_ty  = w_y_p8[7:3];
        w_oob = (w_y_p8[7:3] > ROW_LAST);
      end
      default: begin
        w_tx = r_x[7:3];
      end
    endcase
  end

  // Frame divider: counts every tick regardless of the FSM state.
  always_ff @(posedge S_AXI_ACLK) begin
    if (reset) begin
      r_frame_cnt <= 8'd0;
    end else if (frame_tick) begin
      if (r_frame_cnt == STEP_LAST) begin
        r_frame_cnt <= 8'd0;
      end else begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge S_AXI_ACLK) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state; a QUERY with no request outstanding passes straight on.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = ST_QUERY;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_QUERY: begin
        if (!r_wq_valid || wq_ready) begin
          w_state_nxt = ST_MOVE;
        end else begin
          w_state_nxt = ST_QUERY;
        end
      end
      ST_MOVE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Attempt latch, wall-query handshake and position/animation update.
  always_ff @(posedge S_AXI_ACLK) begin
    if (reset) begin
      r_x        <= X_RST;
      r_y        <= Y_RST;
      r_facing   <= DIR_LEFT;
      r_anim     <= 2'd0;
      r_dir      <= DIR_RIGHT;
      r_wall     <= 1'b0;
      r_wq_valid <= 1'b0;
      r_wq_tx    <= 5'd0;
      r_wq_ty    <= 5'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_dir      <= w_dir;
            r_wall     <= w_oob;
            r_wq_valid <= !(w_skip || w_oob);
            if (!(w_skip || w_oob)) begin
              r_wq_tx <= w_tx;
              r_wq_ty <= w_ty;
            end
          end
        end
        ST_QUERY: begin
          if (r_wq_valid && wq_ready) begin
            r_wq_valid <= 1'b0;
            r_wall     <= wq_wall;
          end
        end
        ST_MOVE: begin
          if (!r_wall) begin
            r_facing <= r_dir;
            r_anim   <= r_anim + 2'd1;
            case (r_dir)
              DIR_RIGHT: r_x <= (r_x == X_WRAP) ? 8'd0 : (r_x + 8'd1);
              DIR_LEFT:  r_x <= (r_x == 8'd0) ? X_WRAP : (r_x - 8'd1);
              DIR_UP:    r_y <= r_y - 8'd1;
              DIR_DOWN:  r_y <= r_y + 8'd1;
              default:   r_x <= r_x;
            endcase
          end
        end
        default: begin
          r_wq_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pm_animator.sv
// Directed bench for pm_animator with hand-computed expectations.
module tb_pm_animator;

  logic        clk;
  logic        reset;
  logic        frame_tick;
  logic [31:0] pm_dir;
  logic [31:0] pm_mv;
  logic        wq_valid;
  logic [4:0]  wq_tx;
  logic [4:0]  wq_ty;
  logic        wq_ready;
  logic        wq_wall;
  logic [31:0] pm_x;
  logic [31:0] pm_y;
  logic [1:0]  pm_facing;
  logic [1:0]  anim_frame;

  int n_checks;
  int n_pass;
  int q_count;
  int valid_cycles;
  int last_tx;
  int last_ty;

  pm_animator dut (
    .S_AXI_ACLK (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .pm_dir     (pm_dir),
    .pm_mv      (pm_mv),
    .wq_valid   (wq_valid),
    .wq_tx      (wq_tx),
    .wq_ty      (wq_ty),
    .wq_ready   (wq_ready),
    .wq_wall    (wq_wall),
    .pm_x       (pm_x),
    .pm_y       (pm_y),
    .pm_facing  (pm_facing),
    .anim_frame (anim_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Query monitor sampled mid-cycle: counts request cycles and handshakes.
  always @(negedge clk) begin
    if (wq_valid) begin
      valid_cycles <= valid_cycles + 1;
      if (wq_ready) begin
        q_count <= q_count + 1;
        last_tx <= int'(wq_tx);
        last_ty <= int'(wq_ty);
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick_once();
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  // Two ticks make one step event; then let the attempt settle.
  task automatic do_step();
    tick_once();
    idle(1);
    tick_once();
    idle(5);
  endtask

  int q0;
  int v0;
  logic stable;

  initial begin
    n_checks = 0; n_pass = 0;
    q_count = 0; valid_cycles = 0; last_tx = 0; last_ty = 0;
    reset = 1'b1; frame_tick = 1'b0; pm_dir = 32'd0; pm_mv = 32'd0;
    wq_ready = 1'b1; wq_wall = 1'b0;
    idle(3);
    reset = 1'b0;
    @(negedge clk);
    check_val("rst_x", pm_x, 32'd108);
    check_val("rst_y", pm_y, 32'd184);
    check_val("rst_facing", {30'd0, pm_facing}, 32'd1);
    check_val("rst_anim", {30'd0, anim_frame}, 32'd0);
    check_val("rst_valid", {31'd0, wq_valid}, 32'd0);
    check_val("rst_tile", {22'd0, wq_tx, wq_ty}, 32'd0);
    @(posedge clk); #1;

    // Move right into an open tile; the first tick alone must not step.
    pm_mv = 32'hFFFF_FF01;
    pm_dir = 32'hABCD_EF00;
    tick_once();
    idle(5);
    check_val("first_tick_no_step", pm_x, 32'd108);
    check_val("first_tick_no_query", q_count, 32'd0);
    tick_once();
    idle(5);
    check_val("right_query_cnt", q_count, 32'd1);
    check_val("right_query_tile", {last_tx[15:0], last_ty[15:0]}, {16'd14, 16'd23});
    check_val("right_x", pm_x, 32'd109);
    check_val("right_facing", {30'd0, pm_facing}, 32'd0);
    check_val("right_anim", {30'd0, anim_frame}, 32'd1);

    // Same attempt against a wall.
    do_reset();
    wq_wall = 1'b1;
    do_step();
    check_val("wall_query_cnt", q_count, 32'd2);
    check_val("wall_x", pm_x, 32'd108);
    check_val("wall_facing", {30'd0, pm_facing}, 32'd1);
    check_val("wall_anim", {30'd0, anim_frame}, 32'd0);
    wq_wall = 1'b0;

    // Unaligned turn request keeps the current heading.
    do_reset();
    pm_dir = 32'd0;
    do_step();
    pm_dir = 32'd2;
    do_step();
    check_val("turn_tile", {last_tx[15:0], last_ty[15:0]}, {16'd14, 16'd23});
    check_val("turn_x", pm_x, 32'd110);
    check_val("turn_y", pm_y, 32'd184);
    check_val("turn_facing", {30'd0, pm_facing}, 32'd0);
    check_val("turn_anim", {30'd0, anim_frame}, 32'd2);

    // Stalled responder: request held, extra step dropped, late dir change ignored.
    pm_dir = 32'd0;
    wq_ready = 1'b0;
    q0 = q_count;
    tick_once();
    idle(1);
    tick_once();
    pm_dir = 32'd1;
    stable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      frame_tick = (i == 1 || i == 3);
      @(negedge clk);
      stable = stable & wq_valid & (wq_tx == 5'd14) & (wq_ty == 5'd23);
      @(posedge clk); #1;
    end
    frame_tick = 1'b0;
    check_val("stall_stable", {31'd0, stable}, 32'd1);
    check_val("stall_x", pm_x, 32'd110);
    check_val("stall_no_handshake", q_count, q0);
    wq_ready = 1'b1;
    idle(8);
    check_val("stall_one_handshake", q_count, q0 + 1);
    check_val("stall_x_after", pm_x, 32'd111);
    check_val("stall_facing", {30'd0, pm_facing}, 32'd0);
    check_val("stall_anim", {30'd0, anim_frame}, 32'd3);
    check_val("stall_valid_low", {31'd0, wq_valid}, 32'd0);

    // Reset overrides an outstanding query.
    pm_dir = 32'd0;
    wq_ready = 1'b0;
    tick_once();
    idle(1);
    tick_once();
    @(negedge clk);
    check_val("pre_reset_valid", {31'd0, wq_valid}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("mid_reset_valid", {31'd0, wq_valid}, 32'd0);
    check_val("mid_reset_x", pm_x, 32'd108);
    check_val("mid_reset_y", pm_y, 32'd184);
    @(posedge clk); #1;
    reset = 1'b0;
    wq_ready = 1'b1;

    // Walk to (0,112): 108 left, then 72 up.
    pm_dir = 32'd1;
    for (int i = 0; i < 108; i++) do_step();
    check_val("walk_left_x", pm_x, 32'd0);
    pm_dir = 32'd2;
    for (int i = 0; i < 72; i++) do_step();
    check_val("walk_up_y", pm_y, 32'd112);
    check_val("walk_up_tile", {last_tx[15:0], last_ty[15:0]}, {16'd0, 16'd14});

    // Tunnel wrap both ways with no wall query.
    v0 = valid_cycles;
    pm_dir = 32'd1;
    do_step();
    check_val("wrap_left_x", pm_x, 32'd216);
    check_val("wrap_left_facing", {30'd0, pm_facing}, 32'd1);
    check_val("wrap_left_noquery", valid_cycles, v0);
    pm_dir = 32'd0;
    do_step();
    check_val("wrap_right_x", pm_x, 32'd0);
    check_val("wrap_right_noquery", valid_cycles, v0);
    check_val("wrap_anim", {30'd0, anim_frame}, 32'd2);

    // Top edge: moving up from row 0 is blocked without a query.
    pm_dir = 32'd2;
    for (int i = 0; i < 112; i++) do_step();
    check_val("top_y", pm_y, 32'd0);
    v0 = valid_cycles;
    do_step();
    check_val("top_block_y", pm_y, 32'd0);
    check_val("top_block_noquery", valid_cycles, v0);
    check_val("top_block_anim", {30'd0, anim_frame}, 32'd2);
    check_val("top_block_facing", {30'd0, pm_facing}, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pm_animator.md
PM_ANIMATOR -- requirements
Module: pm_animator

Interface
REQ-001 SHALL take parameter X_INIT, default 108, meaning reset X pixel position (top-left of 8x8 cell).
REQ-002 SHALL take parameter Y_INIT, default 184, meaning reset Y pixel position.
REQ-003 SHALL take parameter FRAMES_PER_STEP, default 2, range 1..255, meaning frame_tick pulses per movement attempt.
REQ-004 SHALL have port S_AXI_ACLK  in  1  the only clock; all logic on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port frame_tick  in  1  one-cycle pulse per video frame.
REQ-007 SHALL have port pm_dir  in  32  requested direction, bits[1:0]: 0 right, 1 left, 2 up, 3 down; upper bits ignored.
REQ-008 SHALL have port pm_mv  in  32  bit0 = movement enable; upper bits ignored.
REQ-009 SHALL have port wq_valid  out  1  wall-query request.
REQ-010 SHALL have port wq_tx  out  5  queried tile column, 0..27.
REQ-011 SHALL have port wq_ty  out  5  queried tile row, 0..30.
REQ-012 SHALL have port wq_ready  in  1  wall-map responder accepts the query this cycle.
REQ-013 SHALL have port wq_wall  in  1  1 = queried tile is a wall; valid only when wq_valid&wq_ready.
REQ-014 SHALL have port pm_x  out  32  X pixel position, zero-extended from 8 bits.
REQ-015 SHALL have port pm_y  out  32  Y pixel position, zero-extended from 8 bits.
REQ-016 SHALL have port pm_facing  out  2  direction of last successful move, same encoding as pm_dir.
REQ-017 SHALL have port anim_frame  out  2  mouth animation frame.

Function
REQ-018 SHALL keep an 8-bit frame counter: +1 on frame_tick; when it equals FRAMES_PER_STEP-1 on a frame_tick it clears to 0 and raises a step event.
REQ-019 SHALL run FSM IDLE -> QUERY -> MOVE -> IDLE; step event in IDLE with pm_mv[0]=1 enters QUERY next cycle; otherwise the step event is discarded.
REQ-020 Step event arriving while not in IDLE SHALL be discarded; the frame counter keeps counting regardless of state.
REQ-021 On leaving IDLE SHALL latch the attempt direction d = pm_dir[1:0], except d = pm_facing when d is vertical and x[2:0]!=0, or d is horizontal and y[2:0]!=0.
REQ-022 Leading-edge tile SHALL be: right ((x+8)>>3, y>>3); left ((x-1)>>3, y>>3); down (x>>3, (y+8)>>3); up (x>>3, (y-1)>>3).
REQ-023 Horizontal wrap: left at x=0 or right at x=216 SHALL skip the query (treated as open) and go QUERY -> MOVE directly with wq_valid low.
REQ-024 Vertical out-of-range leading tile (row <0 or >30) SHALL be treated as wall without query.
REQ-025 In QUERY, wq_valid SHALL be 1 with stable wq_tx/wq_ty until the cycle wq_ready=1; wq_wall SHALL be sampled that cycle, wq_valid deasserts the next cycle, FSM enters MOVE.
REQ-026 In MOVE with open tile SHALL update position by 1 pixel in d (left at 0 -> 216, right at 216 -> 0), set pm_facing=d, increment anim_frame mod 4; then IDLE.
REQ-027 In MOVE with wall SHALL leave position, pm_facing and anim_frame unchanged; then IDLE.
REQ-028 Changes of pm_dir/pm_mv after latch SHALL not affect the in-flight attempt.
REQ-029 Position change SHALL be visible on pm_x/pm_y the cycle after MOVE; y SHALL never leave 0..240, x never leave 0..216.

Reset
REQ-030 reset SHALL, at the next edge, set x=X_INIT, y=Y_INIT, pm_facing=1, anim_frame=0, frame counter=0, FSM=IDLE, wq_valid=0, wq_tx=wq_ty=0, overriding any in-flight query.
REQ-031 After reset deasserts, the first step event SHALL occur on the FRAMES_PER_STEP-th frame_tick.

Verification
REQ-032 Reset, pm_mv=1, pm_dir=0, FRAMES_PER_STEP=2, wq_ready=1, wq_wall=0, two frame_ticks -> query (14,23), pm_x=109, pm_facing=0, anim_frame=1.
REQ-033 Same but wq_wall=1 -> pm_x stays 108, pm_facing stays 1, anim_frame 0.
REQ-034 x=0,y=112, pm_dir=1, step -> no wq_valid pulse, pm_x=216; then pm_dir=0, step -> pm_x=0.
REQ-035 x=109,y=184, pm_dir=2 -> attempt uses facing 0, query (14,23), pm_x=110.
REQ-036 wq_ready held 0 for 5 cycles with frame_ticks arriving -> wq_valid and tile stable, extra step events dropped, one move only after wq_ready.
REQ-037 reset asserted while wq_valid=1 -> wq_valid=0 and pm_x=108, pm_y=184 next cycle.
